bcd_display_scan: RTL and testbench



---
 rtl/disp_pkg.sv | 20 ++
 rtl/bcd_to_7seg.sv | 32 +++
 rtl/bcd_display_scan.sv | 91 +++++++++
 tb/tb_bcd_display_scan.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared 7-segment constants for multiplexed display blocks
// Patterns are active low, bit order {g,f,e,d,c,b,a}.
package disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - 4-bit code plus blank flag to active-low 7-segment pattern
// Non-BCD codes (10..15) render as a dash; blank overrides everything.
module bcd_to_7seg
    import disp_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (code_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - 4-digit multiplexed common-anode 7-segment scanner
// Digits are snapshotted once per frame so a displayed frame never tears.
module bcd_display_scan
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Qdata3,
    input  logic [3:0] Qdata2,
    input  logic [3:0] Qdata1,
    input  logic [3:0] Qdata0,
    output logic [3:0] an_n,
    output logic [6:0] seg_n,
    output logic       frame_start
);

    localparam int                DIV_W    = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][3:0]  snap_q, snap_d;
    logic [3:0]       an_n_q, an_n_d;
    logic [6:0]       seg_n_q, seg_n_d;
    logic             frame_start_q, frame_start_d;

    logic             tick;
    logic [3:0]       lz_blank;
    logic [3:0]       cur_code;
    logic             cur_blank;
    logic [6:0]       cur_seg;

    // A digit is a leading zero only if it and every more significant digit are 0.
    always_comb begin
        lz_blank    = 4'b0000;
        if (BLANK_LZ) begin
            lz_blank[3] = (snap_q[3] == 4'h0);
            lz_blank[2] = lz_blank[3] && (snap_q[2] == 4'h0);
            lz_blank[1] = lz_blank[2] && (snap_q[1] == 4'h0);
        end
    end

    assign cur_code  = snap_q[idx_q];
    assign cur_blank = lz_blank[idx_q];

    bcd_to_7seg u_dec (
        .code_i  (cur_code),
        .blank_i (cur_blank),
        .seg_o   (cur_seg)
    );

    always_comb begin
        tick          = (div_cnt_q == DIV_LAST);
        div_cnt_d     = tick ? '0 : div_cnt_q + 1'b1;
        idx_d         = tick ? idx_q + 2'd1 : idx_q;
        snap_d        = snap_q;
        frame_start_d = 1'b0;
        if (tick && (idx_q == 2'd3)) begin
            snap_d        = {Qdata3, Qdata2, Qdata1, Qdata0};
            frame_start_d = 1'b1;
        end
        an_n_d        = ~(4'b0001 << idx_q);
        seg_n_d       = cur_seg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            idx_q         <= 2'd0;
            snap_q        <= '0;
            an_n_q        <= AN_OFF;
            seg_n_q       <= SEG_BLANK;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            an_n_q        <= an_n_d;
            seg_n_q       <= seg_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an_n        = an_n_q;
    assign seg_n       = seg_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb/tb_bcd_display_scan.sv - directed self-checking bench for bcd_display_scan
module tb_bcd_display_scan;

    localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010;
    localparam logic [6:0] P6 = 7'b0000010, P7 = 7'b1111000, P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000, PD = 7'b0111111, PB = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] q3, q2, q1, q0;
    logic [3:0] an_n, an_n_b;
    logic [6:0] seg_n, seg_n_b;
    logic       fs, fs_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_display_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .Qdata3(q3), .Qdata2(q2), .Qdata1(q1), .Qdata0(q0),
        .an_n(an_n), .seg_n(seg_n), .frame_start(fs)
    );

    bcd_display_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .Qdata3(q3), .Qdata2(q2), .Qdata1(q1), .Qdata0(q0),
        .an_n(an_n_b), .seg_n(seg_n_b), .frame_start(fs_b)
    );

    typedef struct {
        logic [15:0]     din;
        logic [3:0][6:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [15:0] v);
        {q3, q2, q1, q0} = v;
    endtask

    task automatic wait_frame;
        int n = 0;
        do begin
            step();
            n++;
        end while (!fs && n < 40);
        check("frame_start_seen", {7'd0, fs}, 8'd1);
    endtask

    // Checks one full 16-cycle frame; optionally changes inputs once idx has reached 1.
    task automatic check_frame(input string tag, input logic [3:0][6:0] exp,
                               input logic chg, input logic [15:0] newv);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                if (chg && k == 1 && c == 0) set_in(newv);
                check({tag, "_an"}, {4'd0, an_n}, {4'd0, 4'(~(4'b0001 << k))});
                check({tag, "_seg"}, {1'b0, seg_n}, {1'b0, exp[k]});
                check({tag, "_fs"}, {7'd0, fs}, {7'd0, (k == 3 && c == 3)});
            end
        end
    endtask

    // After reset the snapshot is all zero: digit 0 shows 0, the rest are blank.
    task automatic check_after_reset(input string tag);
        for (int i = 0; i < 16; i++) begin
            step();
            check({tag, "_an"}, {4'd0, an_n}, {4'd0, 4'(~(4'b0001 << (i / 4)))});
            check({tag, "_seg"}, {1'b0, seg_n}, {1'b0, (i < 4) ? P0 : PB});
            check({tag, "_fs"}, {7'd0, fs}, {7'd0, (i == 15)});
        end
    endtask

    initial begin
        vecs[0] = '{16'h1234, {P1, P2, P3, P4}};
        vecs[1] = '{16'h0057, {PB, PB, P5, P7}};
        vecs[2] = '{16'h0000, {PB, PB, PB, P0}};
        vecs[3] = '{16'h1005, {P1, P0, P0, P5}};
        vecs[4] = '{16'hF00A, {PD, P0, P0, PD}};
        vecs[5] = '{16'h9876, {P9, P8, P7, P6}};
        vecs[6] = '{16'h0030, {PB, PB, P3, P0}};
        vecs[7] = '{16'h0800, {PB, P8, P0, P0}};

        // Reset and power-up
        rst = 1'b1;
        set_in(16'h4321);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_an", {4'd0, an_n}, 8'h0F);
            check("rst_seg", {1'b0, seg_n}, 8'h7F);
            check("rst_fs", {7'd0, fs}, 8'd0);
        end
        rst = 1'b0;
        check_after_reset("pwrup");

        // Table-driven full frames
        for (int v = 0; v < 8; v++) begin
            set_in(vecs[v].din);
            wait_frame();
            check_frame($sformatf("vec%0d", v), vecs[v].exp, 1'b0, 16'h0);
        end

        // BLANK_LZ=0 shows every zero
        set_in(16'h0000);
        wait_frame();
        for (int i = 0; i < 16; i++) begin
            step();
            check("nolz_an", {4'd0, an_n_b}, {4'd0, 4'(~(4'b0001 << (i / 4)))});
            check("nolz_seg", {1'b0, seg_n_b}, {1'b0, P0});
        end

        // Anti-tearing: inputs change mid-frame, new value waits for next snapshot
        set_in(16'h1234);
        wait_frame();
        check_frame("tear_old", {P1, P2, P3, P4}, 1'b1, 16'h9876);
        check_frame("tear_new", {P9, P8, P7, P6}, 1'b0, 16'h0);

        // Reset mid-frame while digit 2 is displayed
        set_in(16'h1234);
        wait_frame();
        for (int i = 0; i < 9; i++) step();
        check("mid_pre_an", {4'd0, an_n}, 8'h0B);
        check("mid_pre_seg", {1'b0, seg_n}, {1'b0, P2});
        rst = 1'b1;
        step();
        check("mid_rst_an", {4'd0, an_n}, 8'h0F);
        check("mid_rst_seg", {1'b0, seg_n}, 8'h7F);
        check("mid_rst_fs", {7'd0, fs}, 8'd0);
        rst = 1'b0;
        check_after_reset("mid_post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
